// File: rtl/pr_scheduler.sv
// Partial-reconfiguration scheduler: on an operator miss it either reports a resident hit
// or picks and locks a victim region, drains it, issues one reconfiguration and reports the outcome.
module pr_scheduler #(
    parameter  int OPERATOR_ID_WIDTH = 4,
    parameter  int N_REGIONS         = 4,
    parameter  int QDEPTH            = 16,
    parameter  int TIMEOUT_CYCLES    = 1024,
    localparam int PNTR_BITS         = $clog2(QDEPTH),
    localparam int STAT_W            = OPERATOR_ID_WIDTH + PNTR_BITS,
    localparam int REGION_BITS       = $clog2(N_REGIONS)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_REGIONS*STAT_W-1:0]   region_stats_in,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [OPERATOR_ID_WIDTH-1:0]  miss_oid,
    output logic [N_REGIONS-1:0]          region_lock,
    output logic                          pr_valid,
    input  logic                          pr_ready,
    output logic [REGION_BITS-1:0]        pr_region,
    output logic [OPERATOR_ID_WIDTH-1:0]  pr_oid,
    input  logic                          pr_done,
    input  logic                          pr_error,
    output logic                          done_valid,
    output logic [1:0]                    done_status,
    output logic [REGION_BITS-1:0]        done_region
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_REGIONS-1:0] LOCK_ONE = {{(N_REGIONS-1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_REPORT = 3'd5;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_HIT     = 2'b01;
    localparam logic [1:0] ST_ERROR   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    logic [2:0]                   state;
    logic [OPERATOR_ID_WIDTH-1:0] oid_q;
    logic [REGION_BITS-1:0]       victim_q;
    logic [REGION_BITS-1:0]       result_q;
    logic [1:0]                   status_q;
    logic [N_REGIONS-1:0]         lock_q;
    logic [CNT_W-1:0]             count;

    logic [OPERATOR_ID_WIDTH-1:0] region_oid  [N_REGIONS];
    logic [PNTR_BITS-1:0]         region_load [N_REGIONS];
    logic                         hit;
    logic [REGION_BITS-1:0]       hit_idx;
    logic [REGION_BITS-1:0]       min_idx;
    logic [PNTR_BITS-1:0]         min_load;
    logic                         victim_empty;
    logic                         timed_out;

    // Stats are evaluated live every cycle; the victim's load is re-read while draining.
    // NOTE: every always_comb output gets a default before any conditional update so no latch is inferred.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        min_idx  = '0;
        min_load = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            region_load[i] = region_stats_in[i*STAT_W +: PNTR_BITS];
            region_oid[i]  = region_stats_in[i*STAT_W + PNTR_BITS +: OPERATOR_ID_WIDTH];
        end
        min_load = region_load[0];
        for (int i = 1; i < N_REGIONS; i++) begin
            if (region_load[i] < min_load) begin
                min_load = region_load[i];
                min_idx  = REGION_BITS'(i);
            end
        end
        // Scan downward so the lowest matching index is the one left standing.
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (region_oid[i] == oid_q) begin
                hit     = 1'b1;
                hit_idx = REGION_BITS'(i);
            end
        end
    end

    assign victim_empty = (region_load[victim_q] == '0);
    assign timed_out    = (count == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            oid_q    <= '0;
            victim_q <= '0;
            result_q <= '0;
            status_q <= ST_OK;
            lock_q   <= '0;
            count    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_valid) begin
                        oid_q <= miss_oid;
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (hit) begin
                        status_q <= ST_HIT;
                        result_q <= hit_idx;
                        state    <= S_REPORT;
                    end else begin
                        victim_q <= min_idx;
                        result_q <= min_idx;
                        lock_q   <= LOCK_ONE << min_idx;
                        count    <= '0;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (victim_empty) begin
                        state <= S_ISSUE;
                    end else if (timed_out) begin
                        status_q <= ST_TIMEOUT;
                        state    <= S_REPORT;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (pr_ready) begin
                        count <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pr_error) begin
                        status_q <= ST_ERROR;
                        state    <= S_REPORT;
                    end else if (pr_done) begin
                        status_q <= ST_OK;
                        state    <= S_REPORT;
                    end else if (timed_out) begin
                        status_q <= ST_TIMEOUT;
                        state    <= S_REPORT;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_REPORT: begin
                    lock_q <= '0;
                    state  <= S_IDLE;
                end
                default: begin
                    lock_q <= '0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode straight from state so an asynchronous reset drops them at once.
    assign miss_ready  = (state == S_IDLE);
    assign pr_valid    = (state == S_ISSUE);
    assign done_valid  = (state == S_REPORT);
    assign region_lock = lock_q;
    assign pr_region   = victim_q;
    assign pr_oid      = oid_q;
    assign done_status = status_q;
    assign done_region = result_q;

endmodule

// File: tb/tb_pr_scheduler.sv
// Directed bench for pr_scheduler: expected command/outcome records go into queues that a
// negedge monitor pops whenever the DUT presents a command handshake or an outcome pulse.
module tb_pr_scheduler;

    localparam int OID_W  = 4;
    localparam int NR     = 4;
    localparam int RB     = 2;
    localparam int STAT_W = 8;

    typedef struct packed {
        logic [1:0]    status;
        logic [RB-1:0] region;
    } done_t;

    typedef struct packed {
        logic [RB-1:0]    region;
        logic [OID_W-1:0] oid;
    } cmd_t;

    logic                   aclk = 1'b0;
    logic                   aresetn;
    logic [NR*STAT_W-1:0]   region_stats_in;
    logic                   miss_valid;
    logic                   miss_ready;
    logic [OID_W-1:0]       miss_oid;
    logic [NR-1:0]          region_lock;
    logic                   pr_valid;
    logic                   pr_ready;
    logic [RB-1:0]          pr_region;
    logic [OID_W-1:0]       pr_oid;
    logic                   pr_done;
    logic                   pr_error;
    logic                   done_valid;
    logic [1:0]             done_status;
    logic [RB-1:0]          done_region;

    done_t exp_done_q[$];
    cmd_t  exp_cmd_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    pr_seen = 0;
    int    done_seen = 0;
    int    acc_cycle;

    pr_scheduler #(
        .OPERATOR_ID_WIDTH(OID_W),
        .N_REGIONS        (NR),
        .QDEPTH           (16),
        .TIMEOUT_CYCLES   (8)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .region_stats_in(region_stats_in),
        .miss_valid     (miss_valid),
        .miss_ready     (miss_ready),
        .miss_oid       (miss_oid),
        .region_lock    (region_lock),
        .pr_valid       (pr_valid),
        .pr_ready       (pr_ready),
        .pr_region      (pr_region),
        .pr_oid         (pr_oid),
        .pr_done        (pr_done),
        .pr_error       (pr_error),
        .done_valid     (done_valid),
        .done_status    (done_status),
        .done_region    (done_region)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Raises a miss and returns #1 after the accepting edge, with acc_cycle set to that edge.
    task automatic send_miss(input logic [OID_W-1:0] oid);
        logic rdy;
        bit   ok;
        ok         = 1'b0;
        miss_valid = 1'b1;
        miss_oid   = oid;
        for (int n = 0; n < 12; n++) begin
            rdy = miss_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        acc_cycle  = cyc;
        miss_valid = 1'b0;
        check("miss_accepted", {31'b0, ok}, 32'd1);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        done_t d;
        cmd_t  c;
        forever begin
            @(negedge aclk);
            if (pr_valid) pr_seen++;
            if (pr_valid && pr_ready) begin
                check("cmd_expected", {31'b0, exp_cmd_q.size() != 0}, 32'd1);
                if (exp_cmd_q.size() != 0) begin
                    c = exp_cmd_q.pop_front();
                    check("pr_region", {30'b0, pr_region}, {30'b0, c.region});
                    check("pr_oid", {28'b0, pr_oid}, {28'b0, c.oid});
                end
            end
            if (done_valid) begin
                done_seen++;
                check("done_expected", {31'b0, exp_done_q.size() != 0}, 32'd1);
                if (exp_done_q.size() != 0) begin
                    d = exp_done_q.pop_front();
                    check("done_status", {30'b0, done_status}, {30'b0, d.status});
                    check("done_region", {30'b0, done_region}, {30'b0, d.region});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  pr_before;
        int  done_before;
        int  c1;
        int  n;
        int  rel_cycle;
        bit  stable;

        aresetn         = 1'b0;
        miss_valid      = 1'b0;
        miss_oid        = '0;
        pr_ready        = 1'b0;
        pr_done         = 1'b0;
        pr_error        = 1'b0;
        region_stats_in = 32'h00_35_61_74;

        #13;
        check("rst_miss_ready", {31'b0, miss_ready}, 32'd1);
        check("rst_lock", {28'b0, region_lock}, 32'd0);
        check("rst_pr_valid", {31'b0, pr_valid}, 32'd0);
        check("rst_pr_region", {30'b0, pr_region}, 32'd0);
        check("rst_pr_oid", {28'b0, pr_oid}, 32'd0);
        check("rst_done_valid", {31'b0, done_valid}, 32'd0);
        check("rst_done_status", {30'b0, done_status}, 32'd0);
        check("rst_done_region", {30'b0, done_region}, 32'd0);
        #9 aresetn = 1'b1;

        // Hit on region 1: reported in REPORT, no lock, no command.
        pr_before = pr_seen;
        exp_done_q.push_back('{status: 2'b01, region: 2'd1});
        send_miss(4'd6);
        check("hit_miss_ready_low", {31'b0, miss_ready}, 32'd0);
        tick();
        check("hit_done_valid", {31'b0, done_valid}, 32'd1);
        check("hit_lock", {28'b0, region_lock}, 32'd0);
        tick();
        check("hit_miss_ready_back", {31'b0, miss_ready}, 32'd1);

        // Back-to-back hits are accepted 3 cycles apart.
        exp_done_q.push_back('{status: 2'b01, region: 2'd0});
        send_miss(4'd7);
        c1 = acc_cycle;
        exp_done_q.push_back('{status: 2'b01, region: 2'd3});
        send_miss(4'd0);
        check("hit_interval", acc_cycle - c1, 32'd3);
        tick();
        tick();
        check("hit_no_pr", pr_seen - pr_before, 32'd0);

        // Idle victim: region 3 (load 0) is locked and issued two cycles after SELECT.
        pr_ready = 1'b1;
        exp_cmd_q.push_back('{region: 2'd3, oid: 4'd9});
        exp_done_q.push_back('{status: 2'b00, region: 2'd3});
        send_miss(4'd9);
        tick();
        check("idle_lock", {28'b0, region_lock}, 32'h8);
        check("idle_pr_early", {31'b0, pr_valid}, 32'd0);
        tick();
        check("idle_pr_valid", {31'b0, pr_valid}, 32'd1);
        tick();
        repeat (4) tick();
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        check("idle_done_valid", {31'b0, done_valid}, 32'd1);
        check("idle_lock_in_report", {28'b0, region_lock}, 32'h8);
        tick();
        check("idle_lock_cleared", {28'b0, region_lock}, 32'd0);

        // Drain: region 1 (load 1) is the victim; command waits until its load reaches 0.
        region_stats_in = 32'h82_35_61_74;
        exp_cmd_q.push_back('{region: 2'd1, oid: 4'd9});
        exp_done_q.push_back('{status: 2'b00, region: 2'd1});
        send_miss(4'd9);
        tick();
        check("drain_lock", {28'b0, region_lock}, 32'h2);
        pr_before = pr_seen;
        repeat (5) tick();
        check("drain_pr_held_low", pr_seen - pr_before, 32'd0);
        region_stats_in = 32'h82_35_60_74;
        tick();
        check("drain_pr_valid", {31'b0, pr_valid}, 32'd1);
        check("drain_pr_region", {30'b0, pr_region}, 32'd1);
        tick();
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        check("drain_done_valid", {31'b0, done_valid}, 32'd1);
        tick();

        // Backpressure then simultaneous done/error: error wins.
        region_stats_in = 32'h00_35_61_74;
        pr_ready = 1'b0;
        exp_cmd_q.push_back('{region: 2'd3, oid: 4'd9});
        exp_done_q.push_back('{status: 2'b10, region: 2'd3});
        send_miss(4'd9);
        tick();
        tick();
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!(pr_valid && pr_region == 2'd3 && pr_oid == 4'd9)) stable = 1'b0;
            if (i < 3) tick();
        end
        check("stall_stable", {31'b0, stable}, 32'd1);
        pr_ready = 1'b1;
        tick();
        pr_ready = 1'b0;
        check("stall_released", {31'b0, pr_valid}, 32'd0);
        tick();
        pr_done  = 1'b1;
        pr_error = 1'b1;
        tick();
        pr_done  = 1'b0;
        pr_error = 1'b0;
        check("err_done_status", {30'b0, done_status}, 32'h2);
        tick();

        // Timeout: victim region 3 stuck at load 3 for exactly 8 DRAIN cycles.
        region_stats_in = 32'h13_35_64_74;
        exp_done_q.push_back('{status: 2'b11, region: 2'd3});
        pr_before = pr_seen;
        send_miss(4'd9);
        tick();
        n = 0;
        stable = 1'b1;
        while (!done_valid && n < 20) begin
            if (region_lock != 4'h8) stable = 1'b0;
            tick();
            n++;
        end
        check("timeout_drain_cycles", n, 32'd8);
        check("timeout_lock_held", {31'b0, stable}, 32'd1);
        tick();
        check("timeout_lock_released", {28'b0, region_lock}, 32'd0);
        check("timeout_no_pr", pr_seen - pr_before, 32'd0);

        // Reset in WAIT: outputs drop asynchronously and the aborted request never reports.
        region_stats_in = 32'h00_35_61_74;
        pr_ready = 1'b1;
        exp_cmd_q.push_back('{region: 2'd3, oid: 4'd9});
        send_miss(4'd9);
        tick();
        tick();
        tick();
        pr_ready = 1'b0;
        tick();
        done_before = done_seen;
        check("wait_lock_before_reset", {28'b0, region_lock}, 32'h8);
        #2 aresetn = 1'b0;
        #1;
        check("rst_async_lock", {28'b0, region_lock}, 32'd0);
        check("rst_async_pr_valid", {31'b0, pr_valid}, 32'd0);
        check("rst_async_miss_ready", {31'b0, miss_ready}, 32'd1);
        check("rst_async_pr_oid", {28'b0, pr_oid}, 32'd0);
        check("rst_async_done_status", {30'b0, done_status}, 32'd0);
        @(negedge aclk);
        #2;
        aresetn = 1'b1;
        rel_cycle = cyc;
        exp_done_q.push_back('{status: 2'b01, region: 2'd1});
        send_miss(4'd6);
        check("rst_first_accept", acc_cycle - rel_cycle, 32'd1);
        check("rst_no_done", done_seen - done_before, 32'd0);
        tick();
        tick();
        tick();

        check("cmd_queue_empty", exp_cmd_q.size(), 32'd0);
        check("done_queue_empty", exp_done_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pr_scheduler.md
# pr_scheduler

Partial-reconfiguration scheduler that sits beside the `loadbalancer`. It accepts "operator miss" requests for operators not resident in any region. For each miss it selects a victim region from the per-region `{operator id, queue load}` status vector and locks that region against new dispatch. It then waits for the victim's queue to drain, hands a reconfiguration command to the reconfiguration engine, and reports the outcome. One reconfiguration is in flight at a time.

## Interface
Parameters:
- `OPERATOR_ID_WIDTH`, 4: operator id width.
- `N_REGIONS`, 4: number of reconfigurable regions (≥2).
- `QDEPTH`, 16: region queue depth; `PNTR_BITS = $clog2(QDEPTH)` is the load field width.
- `TIMEOUT_CYCLES`, 1024: cycle limit for DRAIN and WAIT.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous reset, active-low.
- `region_stats_in` in N_REGIONS*(OPERATOR_ID_WIDTH+PNTR_BITS): region i occupies `[i*W +: W]`, where W = OPERATOR_ID_WIDTH+PNTR_BITS; oid in the upper field, load in the lower.
- `miss_valid` in 1 / `miss_ready` out 1 / `miss_oid` in OPERATOR_ID_WIDTH: miss request handshake.
- `region_lock` out N_REGIONS: one-hot; the load balancer must not dispatch to a locked region.
- `pr_valid` out 1 / `pr_ready` in 1 / `pr_region` out $clog2(N_REGIONS) / `pr_oid` out OPERATOR_ID_WIDTH: command to the reconfiguration engine.
- `pr_done` in 1, `pr_error` in 1: single-cycle completion pulses from the engine.
- `done_valid` out 1 / `done_status` out 2 / `done_region` out $clog2(N_REGIONS): outcome pulse, no backpressure. Status codes: 00 = ok-reconfigured, 01 = hit, 10 = error, 11 = timeout.

## Operation
- FSM states: IDLE, SELECT, DRAIN, ISSUE, WAIT, REPORT.
- IDLE:
  - `miss_ready`=1; `miss_ready` is 0 in every other state.
  - On `miss_valid&&miss_ready`, latch `miss_oid` and go to SELECT.
- SELECT (1 cycle): evaluate the current `region_stats_in`.
  - Hit: if any region's oid equals the latched oid, take the lowest such index, set status 01 and go to REPORT. No lock is taken.
  - Miss: the victim is the region with minimum load; ties go to the lowest index.
  - On a miss, set `region_lock[victim]`, clear the timeout counter and go to DRAIN.
- DRAIN:
  - If the victim's load equals 0, go to ISSUE.
  - Else if the counter equals TIMEOUT_CYCLES-1, set status 11 and go to REPORT.
  - Otherwise the counter increments.
- ISSUE:
  - `pr_valid`=1 with `pr_region` = victim and `pr_oid` = latched oid, held stable until `pr_ready`.
  - On `pr_ready`, clear the counter and go to WAIT.
  - There is no timeout in ISSUE.
- WAIT:
  - `pr_error` sets status 10; `pr_done` sets status 00. If both arrive in the same cycle, error wins.
  - Either event goes to REPORT.
  - Otherwise the timeout rule from DRAIN applies, giving status 11.
  - `pr_done`/`pr_error` outside WAIT are ignored.
- REPORT (1 cycle):
  - `done_valid`=1 with `done_status` and `done_region`; `done_region` is the hit or victim index.
  - `region_lock` clears at the exit edge, then return to IDLE.
- Timeout counter is $clog2(TIMEOUT_CYCLES) bits and never wraps. It is cleared on entry to DRAIN and to WAIT.
- Stats are sampled live every cycle; no snapshot is taken.

## Timing
- Reset (async assert, sync deassert use): state=IDLE, `miss_ready`=1, `region_lock`=0, `pr_valid`=0, `pr_region`=0, `pr_oid`=0, `done_valid`=0, `done_status`=0, `done_region`=0, counter=0.
- Miss accepted at edge T:
  - SELECT during T→T+1.
  - Hit: `done_valid` high during cycle T+1→T+2.
  - Miss: lock visible from T+1. With the victim load already 0, `pr_valid` rises at T+2.
- `miss_ready` goes 0 the cycle after acceptance and returns to 1 the cycle after REPORT.
- Minimum miss-to-miss acceptance interval for a hit: 3 cycles.
- Reset mid-operation (any state) immediately drops the lock and `pr_valid`. No `done_valid` is issued for the aborted request.

## Test plan
- Hit: stats 32'h00_35_61_74, miss_oid=6. Expect `done_valid` with status 01 and region 1, `region_lock` stays 0, `pr_valid` never asserted.
- Idle victim:
  - Stimulus: same stats, miss_oid=9, `pr_ready`=1, then a `pr_done` pulse 5 cycles later.
  - Expect lock=4'b1000 and `pr_valid` with region 3 and oid 9 two cycles after SELECT, followed by `done_valid` with status 00 and region 3.
  - Expect the lock to clear after REPORT.
- Drain:
  - Stimulus: stats 32'h82_35_61_74, miss_oid=9; after 6 cycles, region 1's load changes to 0 (stats 32'h82_35_60_74).
  - Expect the victim to be region 1 (load 1), lock=4'b0010, and `pr_valid` held low until load=0, then `pr_region`=1.
- Backpressure and error:
  - Stimulus: `pr_ready` low for 4 cycles, then `pr_done` and `pr_error` in the same cycle.
  - Expect `pr_valid` and `pr_region`/`pr_oid` stable through the stall, and status 10.
- Timeout: TIMEOUT_CYCLES=8 with the victim's load stuck at 3. Expect status 11 after exactly 8 DRAIN cycles, the lock released, and `pr_valid` never asserted.
- Reset in WAIT: deassert `aresetn` mid-WAIT. Expect all outputs at their reset values asynchronously, no `done_valid`, and a new miss accepted the first edge after release.
